freq_meter: RTL

Gate-window frequency counter that measures an external square wave, such as a divided clock, against the board clock `clki`. It counts rising edges of an asynchronous input over a programmable gate of `GATE` `clki` cycles, which is 1 s at 50 MHz by default. At the end of each window it latches the count and pulses `valid`. It sits on the measurement side of the clock-divider outputs and is used to check dividers on hardware and to drive a frequency readout.

---
 rtl/freq_meter.sv | 108 ++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Gate-window frequency counter: counts synchronized rising edges of sig_in
// over GATE clki cycles, then latches the count into freq and pulses valid.
//
// state | meaning
// IDLE  | stopped, counters held at zero, freq/ovf hold last result
// RUN   | gate window in progress, windows run back to back while en=1
module freq_meter #(
  parameter int GATE = 50000000,
  parameter int CW   = 26
) (
  input  logic          clki,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sig_in,
  output logic [CW-1:0] freq,
  output logic          ovf,
  output logic          valid,
  output logic          busy
);

  localparam int GW = (GATE > 1) ? $clog2(GATE) : 1;
  localparam logic [GW-1:0] LAST = GW'(GATE - 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          s1;
  logic          s2;
  logic          s3;
  logic          rise;
  logic [GW-1:0] gate_cnt;
  logic [CW-1:0] edge_cnt;
  logic [CW-1:0] edge_nxt;
  logic          sat;
  logic          add_sat;
  logic          eow;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    eow       = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        eow = (gate_cnt == LAST);
        if (!en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A rise landing on a full counter is dropped and flagged rather than wrapped.
  assign add_sat  = rise && (edge_cnt == CMAX);
  assign edge_nxt = add_sat ? edge_cnt : edge_cnt + CW'(rise);

  // The end-of-window cycle always completes, even if en drops on that cycle.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      freq     <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (eow) begin
        freq     <= edge_nxt;
        ovf      <= sat | add_sat;
        valid    <= 1'b1;
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end else if (state == RUN && en) begin
        gate_cnt <= gate_cnt + GW'(1);
        edge_cnt <= edge_nxt;
        if (add_sat) sat <= 1'b1;
      end else begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN);

endmodule
